// File: rtl/arb41x8_ctl.sv
// Round-robin arbiter steering one of four requester words into a single output register.
// Optional build macro ARB_LOCK_EN adds a lock port that lets the current winner keep priority.
module arb41x8_ctl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
`ifdef ARB_LOCK_EN
    input  logic [3:0]       lock,
`endif
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] dataout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic             state_reg;
    logic [1:0]       ptr_reg;
    logic [1:0]       sel_reg;
    logic [WIDTH-1:0] data_reg;

    logic [WIDTH-1:0] din [4];
    logic [3:0]       rot_req;
    logic [1:0]       offset;
    logic [1:0]       winner;
    logic [1:0]       ptr_next;
    logic             load;
    logic             keep_ptr;

    assign din[0] = a;
    assign din[1] = b;
    assign din[2] = c;
    assign din[3] = d;

    // rot_req[k] is the request seen k places after the pointer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [1:0] OFF = 2'(gi);
            logic [1:0] idx;
            assign idx         = ptr_reg + OFF;
            assign rot_req[gi] = req[idx];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = 2'(k);
            end
        end
    end

    assign winner = ptr_reg + offset;
    // Reset suppresses the load so no requester is acked for a discarded word.
    assign load   = ~reset & (|req) & ((state_reg == EMPTY) | out_ready);
    assign ack    = load ? (4'b0001 << winner) : 4'b0000;

`ifdef ARB_LOCK_EN
    assign keep_ptr = lock[winner];
`else
    assign keep_ptr = 1'b0;
`endif

    assign ptr_next = keep_ptr ? winner : winner + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            ptr_reg   <= 2'd0;
            sel_reg   <= 2'd0;
            data_reg  <= '0;
        end else if (load) begin
            state_reg <= FULL;
            ptr_reg   <= ptr_next;
            sel_reg   <= winner;
            data_reg  <= din[winner];
        end else if (state_reg == FULL && out_ready) begin
            state_reg <= EMPTY;
        end
    end

    assign out_valid = (state_reg == FULL);
    assign sel       = sel_reg;
    assign dataout   = data_reg;

endmodule

// File: tb/tb_arb41x8_ctl.sv
// Bench for arb41x8_ctl: directed vector table, lock sequence (ARB_LOCK_EN) and random traffic vs a model.
module tb_arb41x8_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] a, b, c, d;
    logic [3:0] lock;
    logic [3:0] ack;
    logic [1:0] sel;
    logic [7:0] dataout;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    // Reference state: the word held for the consumer and the next priority slot.
    bit       m_valid;
    int       m_sel;
    int       m_ptr;
    bit [7:0] m_data;

    always #5 clk = ~clk;

    arb41x8_ctl #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack),
        .sel(sel),
        .dataout(dataout),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    typedef struct {
        bit       rst;
        bit       chk;
        bit [3:0] rq;
        bit       ord;
        bit [7:0] cval;
        bit [3:0] eack;
        bit       evalid;
        bit [1:0] esel;
        bit [7:0] edata;
    } vec_t;

    vec_t tab [23];

    function automatic int pick(input bit [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit m_load();
        return !reset && (req != 4'd0) && (!m_valid || out_ready);
    endfunction

    function automatic bit [3:0] m_ack();
        bit [3:0] r;
        r = 4'd0;
        if (m_load()) r[pick(req, m_ptr)] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        int       w;
        bit [7:0] dv [4];
        @(posedge clk);
        dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
        if (reset) begin
            m_valid = 1'b0; m_data = 8'd0; m_sel = 0; m_ptr = 0;
        end else if (m_load()) begin
            w = pick(req, m_ptr);
            $display("xfer: requester %0d data %02h", w, dv[w]);
            m_valid = 1'b1;
            m_data  = dv[w];
            m_sel   = w;
            m_ptr   = lock[w] ? w : (w + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        @(negedge clk);
        chk({tag, ".ack"},     32'(ack),       32'(m_ack()));
        chk({tag, ".valid"},   32'(out_valid), 32'(m_valid));
        chk({tag, ".sel"},     32'(sel),       32'(m_sel));
        chk({tag, ".dataout"}, 32'(dataout),   32'(m_data));
    endtask

    initial begin
        reset = 1'b1; req = 4'h0; out_ready = 1'b0; lock = 4'h0;
        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
        m_valid = 1'b0; m_data = 8'd0; m_sel = 0; m_ptr = 0;

        //         rst chk req  ord cval   ack  vld sel data
        tab[0]  = '{1, 0, 4'hF, 0, 8'h33, 4'h0, 0, 0, 8'h00};
        tab[1]  = '{1, 1, 4'hF, 0, 8'h33, 4'h0, 0, 0, 8'h00};
        tab[2]  = '{0, 1, 4'h4, 1, 8'h5A, 4'h4, 0, 0, 8'h00};
        tab[3]  = '{0, 1, 4'h0, 1, 8'h5A, 4'h0, 1, 2, 8'h5A};
        tab[4]  = '{0, 1, 4'h0, 1, 8'h5A, 4'h0, 0, 2, 8'h5A};
        tab[5]  = '{1, 1, 4'h0, 1, 8'h33, 4'h0, 0, 2, 8'h5A};
        tab[6]  = '{0, 1, 4'hF, 1, 8'h33, 4'h1, 0, 0, 8'h00};
        tab[7]  = '{0, 1, 4'hF, 1, 8'h33, 4'h2, 1, 0, 8'h11};
        tab[8]  = '{0, 1, 4'hF, 1, 8'h33, 4'h4, 1, 1, 8'h22};
        tab[9]  = '{0, 1, 4'hF, 1, 8'h33, 4'h8, 1, 2, 8'h33};
        tab[10] = '{0, 1, 4'hF, 1, 8'h33, 4'h1, 1, 3, 8'h44};
        tab[11] = '{0, 1, 4'h0, 1, 8'h33, 4'h0, 1, 0, 8'h11};
        tab[12] = '{0, 1, 4'h2, 1, 8'h33, 4'h2, 0, 0, 8'h11};
        tab[13] = '{0, 1, 4'h9, 0, 8'h33, 4'h0, 1, 1, 8'h22};
        tab[14] = '{0, 1, 4'h9, 0, 8'h33, 4'h0, 1, 1, 8'h22};
        tab[15] = '{0, 1, 4'h9, 0, 8'h33, 4'h0, 1, 1, 8'h22};
        tab[16] = '{0, 1, 4'h9, 1, 8'h33, 4'h8, 1, 1, 8'h22};
        tab[17] = '{0, 1, 4'h0, 1, 8'h33, 4'h0, 1, 3, 8'h44};
        tab[18] = '{0, 1, 4'h1, 0, 8'h33, 4'h1, 0, 3, 8'h44};
        tab[19] = '{0, 1, 4'h0, 0, 8'h33, 4'h0, 1, 0, 8'h11};
        tab[20] = '{1, 1, 4'hF, 0, 8'h33, 4'h0, 1, 0, 8'h11};
        tab[21] = '{0, 1, 4'hF, 1, 8'h33, 4'h1, 0, 0, 8'h00};
        tab[22] = '{0, 1, 4'h0, 1, 8'h33, 4'h0, 1, 0, 8'h11};

        for (int i = 0; i < 23; i++) begin
            reset = tab[i].rst; req = tab[i].rq; out_ready = tab[i].ord; c = tab[i].cval;
            @(negedge clk);
            if (tab[i].chk) begin
                chk($sformatf("vec%0d.ack", i),     32'(ack),       32'(tab[i].eack));
                chk($sformatf("vec%0d.valid", i),   32'(out_valid), 32'(tab[i].evalid));
                chk($sformatf("vec%0d.sel", i),     32'(sel),       32'(tab[i].esel));
                chk($sformatf("vec%0d.dataout", i), 32'(dataout),   32'(tab[i].edata));
            end
            tick();
        end

`ifdef ARB_LOCK_EN
        // Locked winner keeps priority; after unlock the pointer moves past it.
        reset = 1'b1; req = 4'h0; out_ready = 1'b1; tick();
        reset = 1'b0; req = 4'b0011; lock = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("lock%0d.ack", i), 32'(ack), 32'h1);
            tick();
            @(negedge clk);
            chk($sformatf("lock%0d.sel", i), 32'(sel), 32'h0);
        end
        lock = 4'b0000;
        @(negedge clk); chk("unlock0.ack", 32'(ack), 32'h1); tick();
        @(negedge clk); chk("unlock1.ack", 32'(ack), 32'h2); tick();
        @(negedge clk); chk("unlock1.sel", 32'(sel), 32'h1);
`endif

        // Starvation bound: with all requests up, each requester is granted in any 4 loads.
        reset = 1'b1; req = 4'h0; tick();
        reset = 1'b0; req = 4'hF; out_ready = 1'b1; lock = 4'h0;
        begin
            bit [3:0] seen;
            seen = 4'h0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                seen = seen | ack;
                tick();
            end
            chk("fairness.seen", 32'(seen), 32'hF);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 24) == 0);
            req       = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
`ifdef ARB_LOCK_EN
            lock = 4'($urandom);
`endif
            chk_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
